// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: state encodings, ACK/NACK levels and R/W bit values.
package i2c_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;

  typedef enum logic [3:0] {
    StIdle     = ST_IDLE,
    StAddr     = ST_ADDR,
    StAddrAck  = ST_ADDR_ACK,
    StPtr      = ST_PTR,
    StPtrAck   = ST_PTR_ACK,
    StWdata    = ST_WDATA,
    StWdataAck = ST_WDATA_ACK,
    StRdata    = ST_RDATA,
    StRdataAck = ST_RDATA_ACK
  } i2c_state_e;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Conditions one asynchronous I2C line into the clk domain.
// Build option: I2C_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizer.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   line_in    : raw SCL or SDA
//   level      : conditioned line level
//   rise, fall : single-cycle edge pulses derived from the last two conditioned samples
module i2c_line_sync #(
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  line_s;
  logic                  prev_q;

  // Idle I2C lines are high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], line_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       sync_out;

  assign sync_out = sync_q[SYNC_DEPTH-1];

  // Majority of three consecutive samples: a 1-clk pulse never wins the vote.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_out};
      filt_q <= (sync_out & hist_q[0]) | (sync_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign line_s = filt_q;
`else
  assign line_s = sync_q[SYNC_DEPTH-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= line_s;
    end
  end

  assign level = line_s;
  assign rise  = line_s & ~prev_q;
  assign fall  = ~line_s & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small byte register file; models the on-board temperature sensor.
// Host side preloads registers; committed bus writes are reported as single-cycle strobes.
// Build option: I2C_GLITCH_FILTER_EN (majority filter on SCL/SDA, see i2c_line_sync).
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   SCL               : I2C clock from master (never stretched)
//   SDA               : open-drain data, driven 0 or released
//   host_we/addr/wdata: host register write port
//   bus_wr_valid/addr/data : strobe for each byte committed by a bus write
//   busy              : high from address match until STOP / repeated START / read NACK
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h48,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned SYNC_DEPTH = 2,
  localparam int unsigned PtrW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            SCL,
  inout  wire             SDA,
  input  logic            host_we,
  input  logic [PtrW-1:0] host_addr,
  input  logic [7:0]      host_wdata,
  output logic            bus_wr_valid,
  output logic [PtrW-1:0] bus_wr_addr,
  output logic [7:0]      bus_wr_data,
  output logic            busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_scl_sync (
    .clk    (clk),
    .reset  (reset),
    .line_in(SCL),
    .level  (scl_level),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sda_sync (
    .clk    (clk),
    .reset  (reset),
    .line_in(SDA),
    .level  (sda_level),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  i2c_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            sda_low_q, sda_low_d;
  logic            busy_q, busy_d;
  logic            phase_q, phase_d;  // ACK slot: 0 = before first SCL fall, 1 = slot in progress
  logic            wr_valid_q, wr_valid_d;
  logic [PtrW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [7:0]      regs_q [NUM_REGS];

  logic            start_det, stop_det, last_bit;
  logic [7:0]      byte_in, rd_byte;
  logic [PtrW-1:0] ptr_inc;

  assign start_det = sda_fall & scl_level;
  assign stop_det  = sda_rise & scl_level;
  assign byte_in   = {shift_q[6:0], sda_level};
  assign last_bit  = scl_rise && (bit_cnt_q == 3'd7);
  assign rd_byte   = regs_q[ptr_q];
  assign ptr_inc   = (ptr_q == PtrW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_low_d  = sda_low_q;
    busy_d     = busy_q;
    phase_d    = phase_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = 3'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (last_bit) begin
            phase_d = 1'b0;
            if (state_q == StAddr) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StIdle;
              end
            end else if (state_q == StPtr) begin
              ptr_d   = PtrW'(32'(byte_in) % NUM_REGS);
              state_d = StPtrAck;
            end else begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_in;
              state_d    = StWdataAck;
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_low_d = ~I2C_ACK;
              phase_d   = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              sda_low_d = 1'b0;
              if (state_q == StAddrAck && shift_q[0] == I2C_RW_READ) begin
                // First read bit goes out on the same fall that ends the address ACK.
                shift_d   = rd_byte;
                sda_low_d = ~rd_byte[7];
                state_d   = StRdata;
              end else if (state_q == StWdataAck) begin
                ptr_d   = ptr_inc;
                state_d = StWdata;
              end else if (state_q == StPtrAck) begin
                state_d = StWdata;
              end else begin
                state_d = StPtr;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = StRdataAck;
              phase_d = 1'b0;
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              // Only reached after a master ACK: load the next byte now.
              shift_d   = rd_byte;
              sda_low_d = ~rd_byte[7];
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
            end
          end
        end
        StRdataAck: begin
          if (scl_fall && !phase_q) begin
            sda_low_d = 1'b0;
            phase_d   = 1'b1;
          end else if (scl_rise && phase_q) begin
            phase_d = 1'b0;
            if (sda_level == I2C_NACK) begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end else begin
              ptr_d     = ptr_inc;
              bit_cnt_d = 3'd0;
              state_d   = StRdata;
            end
          end
        end
        default: begin
          state_d   = StIdle;
          sda_low_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      phase_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_low_q  <= sda_low_d;
      busy_q     <= busy_d;
      phase_q    <= phase_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Bus commit is written after the host write so it wins on a same-register collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      if (host_we) begin
        regs_q[host_addr] <= host_wdata;
      end
      if (wr_valid_d) begin
        regs_q[wr_addr_d] <= wr_data_d;
      end
    end
  end

  assign SDA          = sda_low_q ? 1'b0 : 1'bz;
  assign bus_wr_valid = wr_valid_q;
  assign bus_wr_addr  = wr_addr_q;
  assign bus_wr_data  = wr_data_q;
  assign busy         = busy_q;

endmodule
